// File: rtl/reg_text_renderer.sv
// Register-dump text renderer: shadows a register file and IP, emits one glyph request per character.
// Optional dirty-line skipping is enabled by defining REG_TEXT_DIRTY_SKIP_EN.
module reg_text_renderer #(
  parameter int REG_W        = 16,
  parameter int NUM_REGS     = 16,
  parameter int IP_W         = 8,
  parameter int ROWS_PER_COL = 9,
  parameter int ORIGIN_X     = 400,
  parameter int ORIGIN_Y     = 340,
  parameter int COL_PITCH    = 90,
  parameter int CHAR_W       = 8,
  parameter int ROW_H        = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_idx_i,
  input  logic [REG_W-1:0] wr_data_i,
  input  logic [IP_W-1:0]  ip_in_i,
  input  logic             start_i,
  output logic             ch_valid_o,
  input  logic             ch_ready_i,
  output logic [5:0]       ch_code_o,
  output logic [9:0]       ch_x_o,
  output logic [8:0]       ch_y_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int NUM_LINES = NUM_REGS + 2;
  localparam int LW        = $clog2(NUM_LINES);
  localparam int IP_DIG    = IP_W / 4;
  localparam int REG_DIG   = REG_W / 4;
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_EMIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    line_q, line_d;
  logic [3:0]       char_q, char_d;
  logic             ch_valid_q, valid_d;
  logic [5:0]       ch_code_q, code_d;
  logic [9:0]       ch_x_q, x_d;
  logic [8:0]       ch_y_q, y_d;
  logic             busy_q, frame_done_q;

  logic [REG_W-1:0] regs_q   [NUM_REGS];
  logic [REG_W-1:0] shadow_q [NUM_REGS];
  logic [IP_W-1:0]  ip_q, ip_shadow_q;

  logic             accept, skip, line_end, dirty;
  logic [3:0]       len_cur, ridx;
  logic [REG_W-1:0] rsel;
  logic [IP_W-1:0]  ipsel;
  logic [31:0]      val32;
  int               ndig, didx, col, row;

`ifdef REG_TEXT_DIRTY_SKIP_EN
  logic [REG_W-1:0]     last_reg_q [NUM_REGS];
  logic [IP_W-1:0]      last_ip_q;
  logic [NUM_LINES-1:0] drawn_q;
`endif

  function automatic logic [3:0] line_len(input logic [LW-1:0] k);
    if (k == '0) return 4'd10;
    if (k == LW'(1)) return 4'(4 + IP_DIG);
    return 4'(4 + REG_DIG);
  endfunction

  // "REGISTERS." in glyph codes
  function automatic logic [5:0] hdr_code(input logic [3:0] c);
    case (c)
      4'd0, 4'd7: return 6'd27;
      4'd1, 4'd6: return 6'd14;
      4'd2:       return 6'd16;
      4'd3:       return 6'd18;
      4'd4, 4'd8: return 6'd28;
      4'd5:       return 6'd29;
      default:    return 6'd37;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ip_q <= '0;
    end else begin
      ip_q <= ip_in_i;
      if (wr_en_i && int'(wr_idx_i) < NUM_REGS) regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    char_d   = char_q;
    accept   = (state_q == S_EMIT) && ch_valid_q && ch_ready_i;
    skip     = (state_q == S_EMIT) && !ch_valid_q;
    len_cur  = line_len(line_q);
    line_end = accept && (char_q == len_cur - 4'd1);
    case (state_q)
      S_IDLE: if (start_i) state_d = S_SNAP;
      S_SNAP: begin
        state_d = S_EMIT;
        line_d  = '0;
        char_d  = '0;
      end
      S_EMIT: begin
        if (accept && !line_end) begin
          char_d = char_q + 4'd1;
        end else if (line_end || skip) begin
          if (line_q == LAST_LINE) begin
            state_d = S_DONE;
          end else begin
            line_d = line_q + LW'(1);
            char_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // During SNAP the shadow is not loaded yet, so the first glyph reads the live registers.
  always_comb begin
    ridx  = 4'(line_d - LW'(2));
    rsel  = (state_q == S_SNAP) ? regs_q[ridx] : shadow_q[ridx];
    ipsel = (state_q == S_SNAP) ? ip_q : ip_shadow_q;
    val32 = (line_d == LW'(1)) ? 32'(ipsel) : 32'(rsel);
    ndig  = (line_d == LW'(1)) ? IP_DIG : REG_DIG;
    didx  = ndig - 1 - (int'(char_d) - 4);
    code_d = 6'd38;
    if (line_d == '0) begin
      code_d = hdr_code(char_d);
    end else begin
      case (char_d)
        4'd0:    code_d = (line_d == LW'(1)) ? 6'd18 : 6'd27;
        4'd1:    code_d = (line_d == LW'(1)) ? 6'd25 : 6'(ridx);
        4'd2:    code_d = 6'd37;
        4'd3:    code_d = 6'd38;
        default: code_d = 6'((val32 >> (4 * didx)) & 32'hF);
      endcase
    end
    col = int'(line_d) / ROWS_PER_COL;
    row = int'(line_d) % ROWS_PER_COL;
    x_d = 10'(ORIGIN_X + col * COL_PITCH + int'(char_d) * CHAR_W);
    y_d = 9'(ORIGIN_Y + row * ROW_H);
`ifdef REG_TEXT_DIRTY_SKIP_EN
    dirty = !drawn_q[line_d] ||
            ((line_d == LW'(1)) && (ipsel != last_ip_q)) ||
            ((line_d >= LW'(2)) && (rsel != last_reg_q[ridx]));
`else
    dirty = 1'b1;
`endif
    valid_d = (state_d == S_EMIT) && dirty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      char_q       <= '0;
      ch_valid_q   <= 1'b0;
      ch_code_q    <= '0;
      ch_x_q       <= '0;
      ch_y_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ip_shadow_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
`ifdef REG_TEXT_DIRTY_SKIP_EN
      for (int i = 0; i < NUM_REGS; i++) last_reg_q[i] <= '0;
      last_ip_q <= '0;
      drawn_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      char_q       <= char_d;
      ch_valid_q   <= valid_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
      if (valid_d) begin
        ch_code_q <= code_d;
        ch_x_q    <= x_d;
        ch_y_q    <= y_d;
      end
      if (state_q == S_SNAP) begin
        for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= regs_q[i];
        ip_shadow_q <= ip_q;
      end
`ifdef REG_TEXT_DIRTY_SKIP_EN
      if (line_end) begin
        drawn_q[line_q] <= 1'b1;
        if (line_q == LW'(1)) last_ip_q <= ip_shadow_q;
        else if (line_q >= LW'(2)) last_reg_q[4'(line_q - LW'(2))] <= shadow_q[4'(line_q - LW'(2))];
      end
`endif
    end
  end

  assign ch_valid_o   = ch_valid_q;
  assign ch_code_o    = ch_code_q;
  assign ch_x_o       = ch_x_q;
  assign ch_y_o       = ch_y_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_reg_text_renderer.sv
// Scoreboard bench for reg_text_renderer: a string-based text model predicts every glyph of each frame.
// Honours REG_TEXT_DIRTY_SKIP_EN the same way as the design.
module tb_reg_text_renderer;
  localparam int NREG = 16;
  localparam int NL   = NREG + 2;

  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, ch_ready = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  ip_in = '0;
  logic        ch_valid, busy, frame_done;
  logic [5:0]  ch_code;
  logic [9:0]  ch_x;
  logic [8:0]  ch_y;

  always #5 clk = ~clk;

  reg_text_renderer dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .ip_in_i(ip_in), .start_i(start), .ch_valid_o(ch_valid), .ch_ready_i(ch_ready),
    .ch_code_o(ch_code), .ch_x_o(ch_x), .ch_y_o(ch_y), .busy_o(busy), .frame_done_o(frame_done)
  );

  typedef struct {int code; int x; int y;} glyph_t;
  glyph_t exp_q[$];
  int     exp_len_q[$];
  int     tests = 0, fails = 0;
  int     frame_cnt = 0, last_acc = 0, cyc = 0;
  bit     done_seen = 0;
  logic [15:0] mregs [NREG];
`ifdef REG_TEXT_DIRTY_SKIP_EN
  bit    m_drawn [NL];
  string m_last  [NL];
`endif

  function automatic int code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return ch - 48;
    if (ch >= "A" && ch <= "Z") return ch - 55;
    if (ch >= "a" && ch <= "z") return ch - 87;
    if (ch == "-") return 36;
    if (ch == ".") return 37;
    return 38;
  endfunction

  // Builds each text line as a string and queues its glyphs with their screen positions.
  function automatic void model_frame(input logic [7:0] ipv);
    int n = 0;
    string s;
    logic [3:0] r;
    for (int k = 0; k < NL; k++) begin
      if (k == 0) s = "REGISTERS.";
      else if (k == 1) s = $sformatf("IP. %h", ipv);
      else begin
        r = 4'(k - 2);
        s = $sformatf("R%h. %h", r, mregs[k-2]);
      end
`ifdef REG_TEXT_DIRTY_SKIP_EN
      if (m_drawn[k] && s == m_last[k]) continue;
      m_drawn[k] = 1;
      m_last[k]  = s;
`endif
      for (int c = 0; c < s.len(); c++) begin
        glyph_t g;
        g.code = code_of(s[c]);
        g.x    = (400 + (k / 9) * 90 + c * 8) % 1024;
        g.y    = (340 + (k % 9) * 12) % 512;
        exp_q.push_back(g);
      end
      n += s.len();
    end
    exp_len_q.push_back(n);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
`ifdef REG_TEXT_DIRTY_SKIP_EN
    for (int i = 0; i < NL; i++) begin m_drawn[i] = 0; m_last[i] = ""; end
`endif
  endfunction

  // Monitor: compares each accepted glyph, stall stability and frame completion.
  initial begin
    bit stall_prev = 0;
    int pc = 0, px = 0, py = 0;
    glyph_t e;
    int el;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin stall_prev = 0; continue; end
      if (stall_prev) begin
        tests++;
        if (ch_valid !== 1'b1 || int'(ch_code) != pc || int'(ch_x) != px || int'(ch_y) != py) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b code=%0d x=%0d y=%0d, required valid=1 code=%0d x=%0d y=%0d",
                   ch_valid, ch_code, ch_x, ch_y, pc, px, py);
        end
      end
      if (ch_valid && ch_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL glyph_extra: got code=%0d x=%0d y=%0d, required no glyph", ch_code, ch_x, ch_y);
        end else begin
          e = exp_q.pop_front();
          if (int'(ch_code) != e.code || int'(ch_x) != e.x || int'(ch_y) != e.y) begin
            fails++;
            $display("FAIL glyph[%0d]: got code=%0d x=%0d y=%0d, required code=%0d x=%0d y=%0d",
                     frame_cnt, ch_code, ch_x, ch_y, e.code, e.x, e.y);
          end
        end
        frame_cnt++;
        last_acc = cyc;
      end
      stall_prev = ch_valid && !ch_ready;
      pc = int'(ch_code); px = int'(ch_x); py = int'(ch_y);
      if (frame_done) begin
        tests++;
        if (exp_len_q.size() == 0) begin
          fails++;
          $display("FAIL frame_done_unexpected: got frame_done=1, required 0");
        end else begin
          el = exp_len_q.pop_front();
          if (frame_cnt != el || (el > 0 && last_acc != cyc - 1)) begin
            fails++;
            $display("FAIL frame_len: got %0d chars (last accept %0d cycles back), required %0d chars (1 cycle back)",
                     frame_cnt, cyc - last_acc, el);
          end
        end
        frame_cnt = 0;
        done_seen = 1;
      end
    end
  end

  task automatic do_write(input logic [3:0] idx, input logic [15:0] d);
    wr_en = 1; wr_idx = idx; wr_data = d; mregs[idx] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for 5 cycles mid-line.
  task automatic do_frame(input int rmode, input bit wmode, input bit snapwr, input bit chk_lat,
                          input logic [7:0] ipv);
    bit got = 0;
    ip_in = ipv; start = 1; wr_en = 0; ch_ready = 1;
    done_seen = 0;
    model_frame(ipv);
    @(posedge clk); #1;
    start = 0;
    if (chk_lat) begin
      tests++;
      if (busy !== 1'b1 || ch_valid !== 1'b0) begin
        fails++;
        $display("FAIL latency_snap: got busy=%b ch_valid=%b, required busy=1 ch_valid=0", busy, ch_valid);
      end
    end
    if (snapwr) begin wr_en = 1; wr_idx = 4'd15; wr_data = 16'h1234; mregs[15] = 16'h1234; end
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (chk_lat && i == 0) begin
        tests++;
        if (ch_valid !== 1'b1) begin
          fails++;
          $display("FAIL latency_first: got ch_valid=%b, required 1", ch_valid);
        end
      end
      if (done_seen) begin got = 1; break; end
      case (rmode)
        1:       ch_ready = ($urandom_range(0, 3) != 0);
        2:       ch_ready = !(i >= 20 && i < 25);
        default: ch_ready = 1;
      endcase
      wr_en = 0;
      if (wmode && $urandom_range(0, 3) == 0) begin
        wr_en   = 1;
        wr_idx  = 4'($urandom_range(0, 15));
        wr_data = 16'($urandom);
        mregs[wr_idx] = wr_data;
        ip_in   = 8'($urandom);
      end
    end
    wr_en = 0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL frame_timeout: got no frame_done in 3000 cycles, required frame_done");
    end
  endtask

  task automatic do_abort();
    ip_in = 8'h11; start = 1; ch_ready = 1; done_seen = 0;
    model_frame(8'h11);
    repeat (40) begin @(posedge clk); #1; start = 0; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tests++;
    if (ch_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs: got ch_valid=%b busy=%b, required 0 0", ch_valid, busy);
    end
    exp_q.delete(); exp_len_q.delete(); frame_cnt = 0;
    model_reset();
    repeat (6) begin @(posedge clk); #1; end
    tests++;
    if (done_seen) begin
      fails++;
      $display("FAIL abort_frame_done: got frame_done after reset, required none");
    end
  endtask

  initial begin
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ch_valid !== 0 || busy !== 0 || frame_done !== 0 || ch_code !== 0 || ch_x !== 0 || ch_y !== 0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b busy=%b done=%b code=%0d x=%0d y=%0d, required all 0",
               ch_valid, busy, frame_done, ch_code, ch_x, ch_y);
    end
    rst = 0;
    do_frame(0, 0, 0, 1, 8'h00);
    do_write(4'd3, 16'hBEEF);
    do_frame(1, 0, 0, 0, 8'h5A);
    do_frame(2, 1, 0, 0, 8'($urandom));
    do_frame(0, 0, 1, 0, 8'h42);
    do_frame(1, 0, 0, 0, 8'h42);
    repeat (4) do_frame(1, 1, 0, 0, 8'($urandom));
    do_frame(0, 0, 0, 0, 8'h33);
    do_frame(0, 0, 0, 0, 8'h33);
    do_write(4'd8, mregs[8] ^ 16'h00A5);
    do_frame(0, 0, 0, 0, 8'h33);
    do_abort();
    do_frame(1, 0, 0, 1, 8'hC7);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
